reg_bank_rli: RTL and testbench

- Parametrised bank of NUM_REGS general registers for the multicore matrix-multiply datapath. It is the successor to the single load/reset register.
- Each register supports addressed load, per-register clear and per-register increment (for use as an address or index counter). Increment sets a wrap-carry flag.
- A registered read mux drives the shared bus. Zero flags feed the core controller's loop-termination logic.

---
 rtl/reg_bank_rli.sv | 93 +++++++++
 tb/tb_reg_bank_rli.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_rli.sv
// Bank of NUM_REGS general registers with addressed load, per-register clear/increment,
// a registered read mux onto the shared bus, zero flags, wrap-carry and address-error pulses.
module reg_bank_rli #(
    parameter int                 WIDTH     = 16,
    parameter int                 NUM_REGS  = 8,
    parameter int                 SEL_W     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [SEL_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [NUM_REGS-1:0]       clr_en,
    input  logic [NUM_REGS-1:0]       inc_en,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [WIDTH-1:0]          bus_out,
    output logic [NUM_REGS*WIDTH-1:0] regs_flat,
    output logic [NUM_REGS-1:0]       zero_flags,
    output logic [NUM_REGS-1:0]       carry_out,
    output logic                      addr_err
);

    localparam logic [SEL_W:0] NUM_REGS_L = (SEL_W+1)'(NUM_REGS);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [WIDTH-1:0]    bus_q;
    logic [WIDTH-1:0]    bus_d;
    logic [NUM_REGS-1:0] carry_q;
    logic [NUM_REGS-1:0] carry_d;
    logic                addr_err_q;
    logic                addr_err_d;
    logic                wr_in_range_s;
    logic                rd_in_range_s;

    // Next-state selection per register (write > clear > increment > hold) and output staging
    always_comb begin
        wr_in_range_s = ({1'b0, wr_addr} < NUM_REGS_L);
        rd_in_range_s = ({1'b0, rd_sel} < NUM_REGS_L);
        carry_d       = '0;
        bus_d         = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_addr == SEL_W'(i))) begin
                regs_d[i] = wr_data;
            end else if (clr_en[i]) begin
                regs_d[i] = '0;
            end else if (inc_en[i]) begin
                regs_d[i]  = regs_q[i] + WIDTH'(1);
                carry_d[i] = &regs_q[i];
            end else begin
                regs_d[i] = regs_q[i];
            end
            // Read uses pre-update contents; unmatched (out-of-range) selects leave bus at zero
            if (rd_sel == SEL_W'(i)) begin
                bus_d = regs_q[i];
            end else begin
                bus_d = bus_d;
            end
        end
        addr_err_d = (wr_en && !wr_in_range_s) || !rd_in_range_s;
    end

    // State and output registers; synchronous reset discards all same-cycle requests
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            bus_q      <= '0;
            carry_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            bus_q      <= bus_d;
            carry_q    <= carry_d;
            addr_err_q <= addr_err_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
        assign zero_flags[g]               = (regs_q[g] == '0);
    end

    assign bus_out   = bus_q;
    assign carry_out = carry_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_reg_bank_rli.sv
// Bench for reg_bank_rli: an 8-register and a 6-register instance driven in parallel,
// checked every cycle against an array-based model plus directed literal expectations.
module tb_reg_bank_rli;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [15:0]  wr_data;
    logic [7:0]   clr_en;
    logic [7:0]   inc_en;
    logic [2:0]   rd_sel;

    logic [15:0]  bus8, bus6;
    logic [127:0] flat8;
    logic [95:0]  flat6;
    logic [7:0]   zero8, carry8;
    logic [5:0]   zero6, carry6;
    logic         aerr8, aerr6;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // model: index 0 = 8-register bank, index 1 = 6-register bank
    logic [15:0] mr [2][8];
    logic [15:0] mbus [2];
    logic [7:0]  mcarry [2];
    logic        maerr [2];

    always #5 clk = ~clk;

    reg_bank_rli #(.WIDTH(16), .NUM_REGS(8), .SEL_W(3), .RESET_VAL(16'h0000)) dut8 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_en(clr_en), .inc_en(inc_en), .rd_sel(rd_sel), .bus_out(bus8),
        .regs_flat(flat8), .zero_flags(zero8), .carry_out(carry8), .addr_err(aerr8)
    );

    reg_bank_rli #(.WIDTH(16), .NUM_REGS(6), .SEL_W(3), .RESET_VAL(16'h0000)) dut6 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_en(clr_en[5:0]), .inc_en(inc_en[5:0]), .rd_sel(rd_sel), .bus_out(bus6),
        .regs_flat(flat6), .zero_flags(zero6), .carry_out(carry6), .addr_err(aerr6)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] r8(input int i);
        return flat8[i*16 +: 16];
    endfunction

    // Apply the bank rules to the model using the inputs present at this edge
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n;
            logic [15:0] old [8];
            n = (k == 0) ? 8 : 6;
            for (int i = 0; i < 8; i++) old[i] = mr[k][i];
            mcarry[k] = 8'h00;
            if (reset) begin
                for (int i = 0; i < 8; i++) mr[k][i] = 16'h0000;
                mbus[k]  = 16'h0000;
                maerr[k] = 1'b0;
            end else begin
                mbus[k]  = (int'(rd_sel) < n) ? old[rd_sel] : 16'h0000;
                maerr[k] = (wr_en && int'(wr_addr) >= n) || (int'(rd_sel) >= n);
                for (int i = 0; i < n; i++) begin
                    if (wr_en && int'(wr_addr) == i) mr[k][i] = wr_data;
                    else if (clr_en[i]) mr[k][i] = 16'h0000;
                    else if (inc_en[i]) begin
                        mr[k][i] = old[i] + 16'h0001;
                        mcarry[k][i] = (old[i] == 16'hFFFF);
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle();
        wr_en = 1'b0; clr_en = 8'h00; inc_en = 8'h00;
    endtask

    task automatic compare_all();
        logic [127:0] f8;
        logic [95:0]  f6;
        logic [7:0]   z8;
        logic [5:0]   z6;
        for (int i = 0; i < 8; i++) begin
            f8[i*16 +: 16] = mr[0][i];
            z8[i] = (mr[0][i] == 16'h0000);
        end
        for (int i = 0; i < 6; i++) begin
            f6[i*16 +: 16] = mr[1][i];
            z6[i] = (mr[1][i] == 16'h0000);
        end
        chk("regs8", flat8, f8);
        chk("zero8", zero8, z8);
        chk("bus8", bus8, mbus[0]);
        chk("carry8", carry8, mcarry[0]);
        chk("aerr8", aerr8, maerr[0]);
        chk("regs6", flat6, f6);
        chk("zero6", zero6, z6);
        chk("bus6", bus6, mbus[1]);
        chk("carry6", carry6, mcarry[1][5:0]);
        chk("aerr6", aerr6, maerr[1]);
    endtask

    initial begin
        logic [95:0] snap6;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mr[k][i] = 16'h0000;
            mbus[k] = 16'h0000; mcarry[k] = 8'h00; maerr[k] = 1'b0;
        end
        reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
        clr_en = 8'h00; inc_en = 8'h00; rd_sel = 3'd0;

        fork
            forever begin
                @(negedge clk);
                if (chk_on) compare_all();
            end
            begin
                cyc(); cyc();
                chk_on = 1'b1;
                reset = 1'b0;
                cyc();
                chk("rst_regs8", flat8, 128'h0);
                chk("rst_zero8", zero8, 8'hFF);
                chk("rst_zero6", zero6, 6'h3F);
                chk("rst_bus8", bus8, 16'h0000);
                chk("rst_carry8", carry8, 8'h00);
                chk("rst_aerr8", aerr8, 1'b0);

                // write-then-read: no bypass
                wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5; rd_sel = 3'd3;
                cyc();
                chk("rd_same_cycle_old", bus8, 16'h0000);
                chk("wr_visible", r8(3), 16'hA5A5);
                chk("zero3_clear", zero8[3], 1'b0);
                idle();
                cyc();
                chk("rd_next_cycle_new", bus8, 16'hA5A5);

                // increment wrap and carry pulse
                wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hFFFE;
                cyc();
                idle(); inc_en = 8'h20;
                cyc();
                chk("inc_to_ffff", r8(5), 16'hFFFF);
                chk("no_carry_yet", carry8, 8'h00);
                cyc();
                chk("wrap_to_0", r8(5), 16'h0000);
                chk("carry5_pulse", carry8, 8'h20);
                idle();
                cyc();
                chk("carry_one_shot", carry8, 8'h00);
                chk("zero5_back", zero8[5], 1'b1);

                // priority: write > clear > increment
                wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0007;
                cyc();
                wr_data = 16'h0010; clr_en = 8'h04; inc_en = 8'h04;
                cyc();
                chk("prio_write", r8(2), 16'h0010);
                wr_en = 1'b0;
                cyc();
                chk("prio_clear", r8(2), 16'h0000);
                clr_en = 8'h00;
                cyc();
                chk("prio_inc", r8(2), 16'h0001);
                idle();

                // out-of-range on the 6-register bank
                snap6 = flat6;
                wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234; rd_sel = 3'd0;
                cyc();
                chk("oor_wr_aerr6", aerr6, 1'b1);
                chk("oor_wr_aerr8", aerr8, 1'b0);
                chk("oor_wr_nochange", flat6, snap6);
                wr_en = 1'b0; rd_sel = 3'd6;
                cyc();
                chk("oor_rd_bus6", bus6, 16'h0000);
                chk("oor_rd_aerr6", aerr6, 1'b1);
                rd_sel = 3'd0;
                cyc();
                chk("aerr6_drop", aerr6, 1'b0);
                wr_en = 1'b1; wr_addr = 3'd6; rd_sel = 3'd7;
                cyc();
                chk("oor_both_aerr6", aerr6, 1'b1);
                chk("oor_both_aerr8", aerr8, 1'b0);
                idle(); rd_sel = 3'd0;
                cyc();
                chk("aerr6_single", aerr6, 1'b0);

                // reset mid-operation
                for (int i = 0; i < 8; i++) begin
                    wr_en = 1'b1; wr_addr = 3'(i);
                    wr_data = (i == 0 || i == 7) ? 16'hFFFF : 16'h1000 + 16'(i);
                    cyc();
                end
                reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBEEF;
                inc_en = 8'hFF; rd_sel = 3'd7;
                cyc();
                chk("midrst_regs8", flat8, 128'h0);
                chk("midrst_regs6", flat6, 96'h0);
                chk("midrst_carry8", carry8, 8'h00);
                chk("midrst_carry6", carry6, 6'h00);
                chk("midrst_aerr6", aerr6, 1'b0);
                chk("midrst_bus8", bus8, 16'h0000);
                reset = 1'b0; idle();

                // randomized traffic
                for (int c = 0; c < 3000; c++) begin
                    reset   = ($urandom_range(0, 79) == 0);
                    wr_en   = $urandom_range(0, 1) == 1;
                    wr_addr = 3'($urandom_range(0, 7));
                    case ($urandom_range(0, 3))
                        0: wr_data = 16'hFFFF;
                        1: wr_data = 16'hFFFE;
                        2: wr_data = 16'h0000;
                        default: wr_data = 16'($urandom);
                    endcase
                    clr_en  = 8'($urandom) & 8'($urandom) & 8'($urandom);
                    inc_en  = 8'($urandom);
                    rd_sel  = 3'($urandom_range(0, 7));
                    cyc();
                end
                reset = 1'b0; idle();
                cyc(); cyc();
                @(negedge clk);
                #1;
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
